ads8528_seq_ctrl: RTL and testbench

//  Synthesizable sequencer for the ADS8528 8-channel SAR ADC in parallel-bus mode.
//  - Writes the 32-bit config register as two 16-bit bus writes.
//  - On each trigger: fires CONVST_A..D, waits out BUSY, reads CH_A0..CH_D1 (8 words)

---
 rtl/ads8528_pkg.sv | 30 +++
 rtl/ads8528_busy_sync.sv | 24 ++
 rtl/ads8528_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_ads8528_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads8528_pkg.sv
// Shared types and constants for the ADS8528 parallel-bus sequencer.
package ads8528_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCfgW0,
    StCfgW1,
    StConvst,
    StWaitHi,
    StWaitLo,
    StRead
  } state_t;

  localparam int unsigned CfgClkselBit = 29;
  localparam int unsigned NumWords     = 8;

  localparam logic [2:0] ChA0 = 3'd0;
  localparam logic [2:0] ChA1 = 3'd1;
  localparam logic [2:0] ChB0 = 3'd2;
  localparam logic [2:0] ChB1 = 3'd3;
  localparam logic [2:0] ChC0 = 3'd4;
  localparam logic [2:0] ChC1 = 3'd5;
  localparam logic [2:0] ChD0 = 3'd6;
  localparam logic [2:0] ChD1 = 3'd7;

  function automatic logic is_last_word(input logic [2:0] idx);
    return idx == ChD1;
  endfunction

endpackage

// File: rtl/ads8528_busy_sync.sv
// Two-flop synchronizer bringing the ADC BUSY line into the CLK domain.
module ads8528_busy_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/ads8528_seq_ctrl.sv
// ADS8528 parallel-bus sequencer: config writes, conversion trigger, BUSY wait, 8-word readout.
module ads8528_seq_ctrl
  import ads8528_pkg::*;
#(
  parameter int unsigned TCvh     = 2,
  parameter int unsigned TWrl     = 2,
  parameter int unsigned TWrh     = 2,
  parameter int unsigned TRdl     = 3,
  parameter int unsigned TRdh     = 2,
  parameter int unsigned TTimeout = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cfg_word,
  input  logic        cfg_wr,
  input  logic        trig,
  input  logic        BUSY,
  input  logic [15:0] DB_IN,
  output logic [15:0] DB_OUT,
  output logic        DB_OE,
  output logic        CS_N,
  output logic        WR_N,
  output logic        RD_N,
  output logic        CONVST_A,
  output logic        CONVST_B,
  output logic        CONVST_C,
  output logic        CONVST_D,
  output logic        smp_valid,
  output logic [2:0]  smp_ch,
  output logic [15:0] smp_data,
  output logic        frame_done,
  output logic        cfg_done,
  output logic        ctrl_busy,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TTimeout + 1);

  logic busy_s;

  ads8528_busy_sync u_busy_sync (
    .clk_i  (CLK),
    .rst_i  (RST),
    .async_i(BUSY),
    .sync_o (busy_s)
  );

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ph_q, ph_d;        // 0: strobe low phase, 1: strobe high phase
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      cfg_lo_q, cfg_lo_d;
  logic             cfg_pend_q, cfg_pend_d;
  logic             cs_n_q, cs_n_d;
  logic             wr_n_q, wr_n_d;
  logic             rd_n_q, rd_n_d;
  logic             convst_q, convst_d;
  logic             db_oe_q, db_oe_d;
  logic [15:0]      db_out_q, db_out_d;
  logic             smp_valid_q, smp_valid_d;
  logic [2:0]       smp_ch_q, smp_ch_d;
  logic [15:0]      smp_data_q, smp_data_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_done_q, cfg_done_d;
  logic             overrun_q, overrun_d;
  logic             timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ph_d          = ph_q;
    idx_d         = idx_q;
    cfg_lo_d      = cfg_lo_q;
    cfg_pend_d    = cfg_pend_q;
    cs_n_d        = cs_n_q;
    wr_n_d        = wr_n_q;
    rd_n_d        = rd_n_q;
    convst_d      = convst_q;
    db_oe_d       = db_oe_q;
    db_out_d      = db_out_q;
    smp_valid_d   = 1'b0;
    smp_ch_d      = smp_ch_q;
    smp_data_d    = smp_data_q;
    frame_done_d  = 1'b0;
    cfg_done_d    = 1'b0;
    overrun_d     = overrun_q;
    timeout_err_d = timeout_err_q;

    if (state_q != StIdle) begin
      if (cfg_wr) cfg_pend_d = 1'b1;
      if (trig)   overrun_d  = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cfg_wr || cfg_pend_q) begin
          // Config wins; a simultaneous trigger is lost and flagged.
          if (trig) overrun_d = 1'b1;
          state_d    = StCfgW0;
          cfg_lo_d   = cfg_word[15:0];
          cfg_pend_d = 1'b0;
          cs_n_d     = 1'b0;
          db_oe_d    = 1'b1;
          db_out_d   = cfg_word[31:16];
          wr_n_d     = 1'b0;
          ph_d       = 1'b0;
          cnt_d      = CntW'(TWrl - 1);
        end else if (trig) begin
          state_d  = StConvst;
          convst_d = 1'b1;
          cnt_d    = CntW'(TCvh - 1);
        end
      end

      StCfgW0, StCfgW1: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!ph_q) begin
          wr_n_d = 1'b1;
          ph_d   = 1'b1;
          cnt_d  = CntW'(TWrh - 1);
        end else if (state_q == StCfgW0) begin
          state_d  = StCfgW1;
          db_out_d = cfg_lo_q;
          wr_n_d   = 1'b0;
          ph_d     = 1'b0;
          cnt_d    = CntW'(TWrl - 1);
        end else begin
          state_d    = StIdle;
          cfg_done_d = 1'b1;
          cs_n_d     = 1'b1;
          db_oe_d    = 1'b0;
          db_out_d   = '0;
        end
      end

      StConvst: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          convst_d = 1'b0;
          state_d  = StWaitHi;
          cnt_d    = CntW'(TTimeout - 1);
        end
      end

      // One budget covers both the BUSY rise and the BUSY fall.
      StWaitHi, StWaitLo: begin
        if (cnt_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (state_q == StWaitHi && busy_s) begin
            state_d = StWaitLo;
          end else if (state_q == StWaitLo && !busy_s) begin
            state_d = StRead;
            cs_n_d  = 1'b0;
            rd_n_d  = 1'b0;
            ph_d    = 1'b0;
            idx_d   = ChA0;
            cnt_d   = CntW'(TRdl - 1);
          end
        end
      end

      StRead: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!ph_q) begin
          smp_data_d  = DB_IN;
          smp_ch_d    = idx_q;
          smp_valid_d = 1'b1;
          idx_d       = idx_q + 3'd1;
          rd_n_d      = 1'b1;
          if (is_last_word(idx_q)) begin
            frame_done_d = 1'b1;
            cs_n_d       = 1'b1;
            state_d      = StIdle;
          end else begin
            ph_d  = 1'b1;
            cnt_d = CntW'(TRdh - 1);
          end
        end else begin
          rd_n_d = 1'b0;
          ph_d   = 1'b0;
          cnt_d  = CntW'(TRdl - 1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      ph_q          <= 1'b0;
      idx_q         <= '0;
      cfg_lo_q      <= '0;
      cfg_pend_q    <= 1'b0;
      cs_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      convst_q      <= 1'b0;
      db_oe_q       <= 1'b0;
      db_out_q      <= '0;
      smp_valid_q   <= 1'b0;
      smp_ch_q      <= '0;
      smp_data_q    <= '0;
      frame_done_q  <= 1'b0;
      cfg_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ph_q          <= ph_d;
      idx_q         <= idx_d;
      cfg_lo_q      <= cfg_lo_d;
      cfg_pend_q    <= cfg_pend_d;
      cs_n_q        <= cs_n_d;
      wr_n_q        <= wr_n_d;
      rd_n_q        <= rd_n_d;
      convst_q      <= convst_d;
      db_oe_q       <= db_oe_d;
      db_out_q      <= db_out_d;
      smp_valid_q   <= smp_valid_d;
      smp_ch_q      <= smp_ch_d;
      smp_data_q    <= smp_data_d;
      frame_done_q  <= frame_done_d;
      cfg_done_q    <= cfg_done_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign DB_OUT      = db_out_q;
  assign DB_OE       = db_oe_q;
  assign CS_N        = cs_n_q;
  assign WR_N        = wr_n_q;
  assign RD_N        = rd_n_q;
  assign CONVST_A    = convst_q;
  assign CONVST_B    = convst_q;
  assign CONVST_C    = convst_q;
  assign CONVST_D    = convst_q;
  assign smp_valid   = smp_valid_q;
  assign smp_ch      = smp_ch_q;
  assign smp_data    = smp_data_q;
  assign frame_done  = frame_done_q;
  assign cfg_done    = cfg_done_q;
  assign ctrl_busy   = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ads8528_seq_ctrl.sv
// Directed bench for ads8528_seq_ctrl with a small behavioural ADC and bus monitors.
module tb_ads8528_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] cfg_word = '0;
  logic        cfg_wr = 1'b0;
  logic        trig = 1'b0;
  logic        BUSY = 1'b0;
  logic [15:0] DB_IN = '0;
  logic [15:0] DB_OUT;
  logic        DB_OE, CS_N, WR_N, RD_N;
  logic        CONVST_A, CONVST_B, CONVST_C, CONVST_D;
  logic        smp_valid;
  logic [2:0]  smp_ch;
  logic [15:0] smp_data;
  logic        frame_done, cfg_done, ctrl_busy, overrun, timeout_err;

  always #5 CLK = ~CLK;

  ads8528_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .cfg_word   (cfg_word),
    .cfg_wr     (cfg_wr),
    .trig       (trig),
    .BUSY       (BUSY),
    .DB_IN      (DB_IN),
    .DB_OUT     (DB_OUT),
    .DB_OE      (DB_OE),
    .CS_N       (CS_N),
    .WR_N       (WR_N),
    .RD_N       (RD_N),
    .CONVST_A   (CONVST_A),
    .CONVST_B   (CONVST_B),
    .CONVST_C   (CONVST_C),
    .CONVST_D   (CONVST_D),
    .smp_valid  (smp_valid),
    .smp_ch     (smp_ch),
    .smp_data   (smp_data),
    .frame_done (frame_done),
    .cfg_done   (cfg_done),
    .ctrl_busy  (ctrl_busy),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural ADC: random words per frame, BUSY pulse after each CONVST rise.
  logic        no_busy = 1'b0;
  logic [15:0] words[8];
  int          rd_idx = 0;

  initial forever begin
    @(posedge CONVST_A);
    for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
    rd_idx = 0;
    if (!no_busy) begin
      repeat (3) @(posedge CLK);
      #2 BUSY = 1'b1;
      repeat (20) @(posedge CLK);
      #2 BUSY = 1'b0;
    end
  end

  always @(negedge RD_N) begin
    DB_IN = words[rd_idx % 8];
    rd_idx++;
  end

  // Bus monitors.
  int          wr_cnt, wr_w, rd_w, cv_w, cv_cnt, smp_cnt, smp_idx, fd_cnt, cd_cnt, wr_at_fd;
  logic [15:0] wr_words[4];

  always @(negedge CLK) begin
    if (RST) begin
      wr_w = 0;
      rd_w = 0;
      cv_w = 0;
    end else begin
      if (!WR_N) begin
        wr_w++;
        if (wr_w == 1) begin
          if (wr_cnt < 4) wr_words[wr_cnt] = DB_OUT;
          wr_cnt++;
          check("wr_cs_n", 32'(CS_N), 0);
          check("wr_db_oe", 32'(DB_OE), 1);
        end
      end else if (wr_w != 0) begin
        check("wr_low_width", wr_w, 2);
        wr_w = 0;
      end
      if (!RD_N) begin
        rd_w++;
        if (rd_w == 1) begin
          check("rd_cs_n", 32'(CS_N), 0);
          check("rd_db_oe", 32'(DB_OE), 0);
        end
      end else if (rd_w != 0) begin
        check("rd_low_width", rd_w, 3);
        rd_w = 0;
      end
      if (!(WR_N && RD_N)) check("wr_rd_excl", 32'(WR_N | RD_N), 1);
      if (CONVST_A | CONVST_B | CONVST_C | CONVST_D)
        check("convst_equal", {CONVST_A, CONVST_B, CONVST_C, CONVST_D}, 4'hF);
      if (CONVST_A) begin
        cv_w++;
        if (cv_w == 1) begin
          cv_cnt++;
          smp_idx = 0;
        end
      end else if (cv_w != 0) begin
        check("convst_width", cv_w, 2);
        cv_w = 0;
      end
      if (smp_valid) begin
        check("smp_ch", 32'(smp_ch), smp_idx % 8);
        check("smp_data", 32'(smp_data), 32'(words[smp_idx % 8]));
        smp_idx++;
        smp_cnt++;
      end
      if (frame_done) begin
        check("fd_with_last", {smp_valid, smp_ch}, 4'hF);
        fd_cnt++;
        wr_at_fd = wr_cnt;
      end
      if (cfg_done) cd_cnt++;
    end
  end

  task automatic clr();
    wr_cnt = 0; cv_cnt = 0; smp_cnt = 0; fd_cnt = 0; cd_cnt = 0; wr_at_fd = -1;
    for (int i = 0; i < 4; i++) wr_words[i] = '0;
  endtask

  task automatic pulse(input logic c, input logic t);
    @(posedge CLK);
    #1 cfg_wr = c; trig = t;
    @(posedge CLK);
    #1 cfg_wr = 1'b0; trig = 1'b0;
  endtask

  // kind: 0 frame_done, 1 cfg_done, 2 timeout_err, 3 RD_N low, 4 four samples seen.
  task automatic wait_for(input int kind, input string tag, input int budget, output int cyc);
    logic hit;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      unique case (kind)
        0:       hit = (fd_cnt != 0);
        1:       hit = (cd_cnt != 0);
        2:       hit = timeout_err;
        3:       hit = !RD_N;
        default: hit = (smp_cnt >= 4);
      endcase
    end
    if (!hit) check(tag, 0, 1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  int cyc;

  initial begin
    clr();
    do_reset();
    @(negedge CLK);
    check("rst_strobes", {CS_N, WR_N, RD_N, CONVST_A, CONVST_B, CONVST_C, CONVST_D}, 7'b1110000);
    check("rst_db", {DB_OE, DB_OUT}, 0);
    check("rst_pulses", {smp_valid, frame_done, cfg_done, ctrl_busy}, 0);
    check("rst_sticky", {overrun, timeout_err}, 0);

    // Config write.
    clr();
    cfg_word = 32'hA000_03FF;
    pulse(1'b1, 1'b0);
    wait_for(1, "t1_cfg_done_timeout", 100, cyc);
    repeat (5) @(negedge CLK);
    check("t1_wr_cnt", wr_cnt, 2);
    check("t1_word_hi", 32'(wr_words[0]), 32'h0000_A000);
    check("t1_word_lo", 32'(wr_words[1]), 32'h0000_03FF);
    check("t1_cfg_done_cnt", cd_cnt, 1);
    check("t1_idle", {ctrl_busy, CS_N, DB_OE}, 3'b010);

    // Normal frame.
    clr();
    pulse(1'b0, 1'b1);
    wait_for(0, "t2_frame_timeout", 300, cyc);
    repeat (5) @(negedge CLK);
    check("t2_smp_cnt", smp_cnt, 8);
    check("t2_fd_cnt", fd_cnt, 1);
    check("t2_cv_cnt", cv_cnt, 1);
    check("t2_flags", {overrun, timeout_err, ctrl_busy, CS_N}, 4'b0001);

    // BUSY never rises.
    clr();
    no_busy = 1'b1;
    pulse(1'b0, 1'b1);
    wait_for(2, "t3_timeout_missing", 5000, cyc);
    check("t3_timeout_lat", 32'(cyc >= 4096 && cyc <= 4100), 1);
    @(negedge CLK);
    check("t3_smp_cnt", smp_cnt, 0);
    check("t3_idle", {ctrl_busy, timeout_err, CS_N}, 3'b011);
    no_busy = 1'b0;
    clr();
    pulse(1'b0, 1'b1);
    wait_for(0, "t3_frame_timeout", 300, cyc);
    repeat (3) @(negedge CLK);
    check("t3_recover_smp", smp_cnt, 8);

    // trig and cfg_wr during READ.
    clr();
    cfg_word = 32'h1234_5678;
    pulse(1'b0, 1'b1);
    wait_for(3, "t4_read_timeout", 300, cyc);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    wait_for(0, "t4_frame_timeout", 300, cyc);
    wait_for(1, "t4_cfg_timeout", 100, cyc);
    repeat (3) @(negedge CLK);
    check("t4_overrun", 32'(overrun), 1);
    check("t4_smp_cnt", smp_cnt, 8);
    check("t4_wr_before_fd", wr_at_fd, 0);
    check("t4_wr_cnt", wr_cnt, 2);
    check("t4_word_hi", 32'(wr_words[0]), 32'h0000_1234);
    check("t4_word_lo", 32'(wr_words[1]), 32'h0000_5678);

    do_reset();
    @(negedge CLK);
    check("rst_clears_sticky", {overrun, timeout_err}, 0);

    // cfg_wr and trig on the same cycle.
    clr();
    cfg_word = 32'hCAFE_0001;
    pulse(1'b1, 1'b1);
    wait_for(1, "t5_cfg_timeout", 100, cyc);
    repeat (60) @(negedge CLK);
    check("t5_word_hi", 32'(wr_words[0]), 32'h0000_CAFE);
    check("t5_word_lo", 32'(wr_words[1]), 32'h0000_0001);
    check("t5_overrun", 32'(overrun), 1);
    check("t5_no_frame", cv_cnt + smp_cnt, 0);
    check("t5_idle", 32'(ctrl_busy), 0);

    // Reset in the middle of the fifth read.
    clr();
    pulse(1'b0, 1'b1);
    wait_for(4, "t6_four_timeout", 300, cyc);
    wait_for(3, "t6_rd4_timeout", 50, cyc);
    #2 RST = 1'b1;
    #1 check("t6_async_release", {RD_N, CS_N, smp_valid}, 3'b110);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (50) @(negedge CLK);
    check("t6_smp_cnt", smp_cnt, 4);
    check("t6_fd_cnt", fd_cnt, 0);
    check("t6_idle", 32'(ctrl_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
